block_move: RTL and testbench
=============================

BLOCK_MOVE -- requirements
Module: block_move

Interface
REQ-001 SHALL have parameter H_ACT, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACT, default 480, active lines per frame.
REQ-003 SHALL have parameter BLK_SIZE, default 64, square edge length in pixels.
REQ-004 SHALL have parameter STEP, default 2, pixels moved per update, both axes.
REQ-005 SHALL have parameter FRAME_DIV, default 1, frames per position update (1..255).
REQ-006 SHALL have parameter BG_COLOR, default 24'h000000, background RGB888.
REQ-007 SHALL have port clk  input  1  pixel clock (25 MHz PLL output).
REQ-008 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-009 SHALL have port frame_start  input  1  single-cycle pulse at start of vertical blanking from the VGA timing stage.
REQ-010 SHALL have port pix_req  input  1  high when the timing stage requests an active pixel.
REQ-011 SHALL have port pix_x  input  11  requested column, 0..H_ACT-1, valid with pix_req.
REQ-012 SHALL have port pix_y  input  11  requested row, 0..V_ACT-1, valid with pix_req.
REQ-013 SHALL have port pause  input  1  high freezes motion; rendering continues.
REQ-014 SHALL have port pix_data  output  24  RGB888 {R,G,B} for the requested pixel.
REQ-015 SHALL have port pix_valid  output  1  pix_data qualifier.

Function
REQ-016 SHALL hold registers x_pos, y_pos (11 bit, square top-left), dir_x, dir_y (1 = increasing), color_idx (2 bit), frame_cnt (8 bit).
REQ-017 SHALL render with latency exactly 1 clk: pix_valid(n+1)=pix_req(n); pix_data(n+1) computed from pix_x/pix_y(n).
REQ-018 SHALL output square color when x_pos<=pix_x<x_pos+BLK_SIZE and y_pos<=pix_y<y_pos+BLK_SIZE, else BG_COLOR; pix_data SHALL be 0 when pix_req was low.
REQ-019 SHALL map color_idx 0..3 to 24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00.
REQ-020 SHALL, on each frame_start with pause low, increment frame_cnt; when frame_cnt reaches FRAME_DIV-1 it SHALL clear to 0 and perform one position update in that same cycle.
REQ-021 SHALL, with pause high, ignore frame_start entirely (frame_cnt and position held).
REQ-022 Position update, X axis: dir_x=1 and x_pos+BLK_SIZE+STEP>=H_ACT -> x_pos=H_ACT-BLK_SIZE, dir_x=0; dir_x=0 and x_pos<=STEP -> x_pos=0, dir_x=1; otherwise x_pos+=STEP or -=STEP.
REQ-023 Y axis SHALL follow REQ-022 with y_pos, dir_y, V_ACT.
REQ-024 SHALL increment color_idx by 1 (wrap 3->0) on any update where at least one axis bounces; simultaneous X and Y bounce (corner) SHALL increment once only.
REQ-025 SHALL keep x_pos in 0..H_ACT-BLK_SIZE and y_pos in 0..V_ACT-BLK_SIZE at all times; no arithmetic underflow (compare before subtract).
REQ-026 SHALL apply position updates only at frame_start so the square never tears within a displayed frame.
REQ-027 frame_start coincident with pix_req SHALL render that pixel with the pre-update position.
REQ-028 All arithmetic SHALL be unsigned, 12-bit intermediate for sums to prevent overflow.

Reset
REQ-029 On rst_n low, asynchronously: x_pos=0, y_pos=0, dir_x=1, dir_y=1, color_idx=0, frame_cnt=0, pix_data=0, pix_valid=0.
REQ-030 Reset asserted mid-frame SHALL take effect immediately; first update after release uses the reset state.

Verification
REQ-031 Reset, then pix_req=1 at (0,0) and (63,63) -> pix_data=24'hFF0000 next cycle; (64,0) -> 24'h000000; pix_valid follows pix_req by 1 clk.
REQ-032 One frame_start (FRAME_DIV=1) -> x_pos=2, y_pos=2; pixel (1,1) -> BG, (2,2) -> 24'hFF0000.
REQ-033 Force x_pos=574, dir_x=1, y_pos=100, frame_start -> x_pos=576, dir_x=0, color_idx=1 (pix_data 24'h00FF00 inside square).
REQ-034 Corner: x_pos=576, y_pos=416, dir_x=dir_y=1, frame_start -> dir_x=dir_y=0, positions unchanged, color_idx advances by exactly 1.
REQ-035 pause=1 over 5 frame_start pulses -> x_pos, y_pos, frame_cnt unchanged; FRAME_DIV=3 with pause=0 -> update on every 3rd pulse only.
REQ-036 Assert rst_n low mid-line with pix_req=1 -> pix_valid and pix_data go 0 without waiting for clk; all state equals REQ-029 values.

Source files
------------

// File: rtl/block_move.sv
`default_nettype none
// ============================================================================
// Module      : block_move
// Description : Bouncing-square pattern generator for a VGA pixel pipeline.
//               A BLK_SIZE x BLK_SIZE square moves STEP pixels per axis once
//               every FRAME_DIV frames. It reflects off the active-area edges
//               and changes colour on every bounce. Pixels are rendered on
//               request with a fixed one-clock latency.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1   pixel clock
//   rst_n       in   1   asynchronous active-low reset
//   frame_start in   1   one-cycle pulse at start of vertical blanking
//   pix_req     in   1   active pixel requested this cycle
//   pix_x       in  11   requested column (valid with pix_req)
//   pix_y       in  11   requested row    (valid with pix_req)
//   pause       in   1   freeze motion; rendering continues
//   pix_data    out 24   RGB888 {R,G,B}, one clock after the request
//   pix_valid   out  1   pix_data qualifier (pix_req delayed one clock)
// ============================================================================
module block_move #(
  parameter int          H_ACT     = 640,
  parameter int          V_ACT     = 480,
  parameter int          BLK_SIZE  = 64,
  parameter int          STEP      = 2,
  parameter int          FRAME_DIV = 1,
  parameter logic [23:0] BG_COLOR  = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pix_req,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  input  logic        pause,
  output logic [23:0] pix_data,
  output logic        pix_valid
);

  // Sums are formed 12 bits wide so pos + BLK_SIZE + STEP cannot wrap.
  localparam logic [11:0] H_ACT_W  = 12'(H_ACT);
  localparam logic [11:0] V_ACT_W  = 12'(V_ACT);
  localparam logic [11:0] BLK_W    = 12'(BLK_SIZE);
  localparam logic [11:0] STEP_W   = 12'(STEP);
  localparam logic [10:0] STEP_S   = 11'(STEP);
  localparam logic [10:0] X_MAX    = 11'(H_ACT - BLK_SIZE);
  localparam logic [10:0] Y_MAX    = 11'(V_ACT - BLK_SIZE);
  localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);

  // Result of advancing one axis by one step.
  typedef struct packed {
    logic [10:0] pos;
    logic        dir;
    logic        bounce;
  } axis_t;

  // One-axis motion with reflection. The far edge is tested on the 12-bit
  // sum. The near edge is tested before subtracting, so pos never underflows.
  // When the next step would cross an edge, the position is clamped exactly
  // onto that edge and the direction flips.
  function automatic axis_t axis_next(
    input logic [10:0] pos,
    input logic        dir,
    input logic [11:0] limit,
    input logic [10:0] max_pos
  );
    axis_t r;
    r = '{pos: pos, dir: dir, bounce: 1'b0};
    if (dir) begin
      if (({1'b0, pos} + BLK_W + STEP_W) >= limit) begin
        r = '{pos: max_pos, dir: 1'b0, bounce: 1'b1};
      end else begin
        r.pos = pos + STEP_S;
      end
    end else begin
      if (pos <= STEP_S) begin
        r = '{pos: 11'd0, dir: 1'b1, bounce: 1'b1};
      end else begin
        r.pos = pos - STEP_S;
      end
    end
    return r;
  endfunction

  // --------------------------------------------------------------------------
  // Motion state
  // --------------------------------------------------------------------------
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic        dir_x;
  logic        dir_y;
  logic [1:0]  color_idx;
  logic [7:0]  frame_cnt;

  logic        advance;     // frame_start that is not masked by pause
  logic        do_update;   // this frame_start also moves the square
  axis_t       x_next;
  axis_t       y_next;

  always_comb begin
    advance   = frame_start & ~pause;
    do_update = advance && (frame_cnt == DIV_LAST);
    x_next    = axis_next(x_pos, dir_x, H_ACT_W, X_MAX);
    y_next    = axis_next(y_pos, dir_y, V_ACT_W, Y_MAX);
  end

  // Motion state changes only on frame_start, so the square is never torn
  // within a displayed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos     <= 11'd0;
      y_pos     <= 11'd0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      color_idx <= 2'd0;
      frame_cnt <= 8'd0;
    end else if (advance) begin
      if (do_update) begin
        frame_cnt <= 8'd0;
        x_pos     <= x_next.pos;
        y_pos     <= y_next.pos;
        dir_x     <= x_next.dir;
        dir_y     <= y_next.dir;
        // A corner bounce counts as a single bounce.
        if (x_next.bounce || y_next.bounce) begin
          color_idx <= color_idx + 2'd1;
        end
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Rendering
  // --------------------------------------------------------------------------
  logic [11:0] px_w;
  logic [11:0] py_w;
  logic [11:0] xp_w;
  logic [11:0] yp_w;
  logic        in_x;
  logic        in_y;
  logic [23:0] sq_color;
  logic [23:0] pixel;

  always_comb begin
    px_w = {1'b0, pix_x};
    py_w = {1'b0, pix_y};
    xp_w = {1'b0, x_pos};
    yp_w = {1'b0, y_pos};
    in_x = (px_w >= xp_w) && (px_w < (xp_w + BLK_W));
    in_y = (py_w >= yp_w) && (py_w < (yp_w + BLK_W));

    case (color_idx)
      2'd0:    sq_color = 24'hFF0000;
      2'd1:    sq_color = 24'h00FF00;
      2'd2:    sq_color = 24'h0000FF;
      default: sq_color = 24'hFFFF00;
    endcase

    pixel = (in_x && in_y) ? sq_color : BG_COLOR;
  end

  // The hit test uses the current (pre-update) position. A pixel that is
  // requested in the same cycle as frame_start therefore still shows the old
  // frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data  <= 24'h000000;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= pix_req;
      pix_data  <= pix_req ? pixel : 24'h000000;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_block_move.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_move
// Description : Directed self-checking bench for block_move. Three instances
//               are used: default geometry, FRAME_DIV=3, and a 16x16 field
//               with a 4-pixel square so that corner bounces occur quickly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_move;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pause;
  logic        pix_req;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        fs_main;
  logic        fs_div3;
  logic        fs_small;
  logic [23:0] data_main, data_div3, data_small;
  logic        valid_main, valid_div3, valid_small;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  block_move dut (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_main), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .pause(pause),
    .pix_data(data_main), .pix_valid(valid_main)
  );

  block_move #(.FRAME_DIV(3)) dut_div3 (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_div3), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .pause(pause),
    .pix_data(data_div3), .pix_valid(valid_div3)
  );

  block_move #(.H_ACT(16), .V_ACT(16), .BLK_SIZE(4), .STEP(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_small), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .pause(pause),
    .pix_data(data_small), .pix_valid(valid_small)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = main, 1 = div3, 2 = small, 3 = main and div3 together
  task automatic pulse(input int sel, input int n);
    for (int i = 0; i < n; i++) begin
      fs_main  = (sel == 0) || (sel == 3);
      fs_div3  = (sel == 1) || (sel == 3);
      fs_small = (sel == 2);
      tick();
      fs_main = 1'b0; fs_div3 = 1'b0; fs_small = 1'b0;
      tick();
    end
  endtask

  task automatic request(input int x, input int y);
    pix_req = 1'b1; pix_x = 11'(x); pix_y = 11'(y);
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; pause = 1'b0; pix_req = 1'b0; pix_x = '0; pix_y = '0;
    fs_main = 1'b0; fs_div3 = 1'b0; fs_small = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    vectors++; if (valid_main !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_main); end
    vectors++; if (data_main !== 24'h0) begin miscompares++; $display("FAIL reset_data: got %h want 000000", data_main); end
    vectors++; if (dut.x_pos !== 11'd0 || dut.y_pos !== 11'd0) begin miscompares++; $display("FAIL reset_pos: got %0d,%0d want 0,0", dut.x_pos, dut.y_pos); end
    vectors++; if (dut.dir_x !== 1'b1 || dut.dir_y !== 1'b1) begin miscompares++; $display("FAIL reset_dir: got %b%b want 11", dut.dir_x, dut.dir_y); end
    vectors++; if (dut.color_idx !== 2'd0 || dut.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got color %0d cnt %0d want 0 0", dut.color_idx, dut.frame_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_render();
    request(0, 0);
    vectors++; if (valid_main !== 1'b1) begin miscompares++; $display("FAIL render_valid: got %b want 1", valid_main); end
    vectors++; if (data_main !== 24'hFF0000) begin miscompares++; $display("FAIL render_00: got %h want ff0000", data_main); end
    request(63, 63);
    vectors++; if (data_main !== 24'hFF0000) begin miscompares++; $display("FAIL render_63: got %h want ff0000", data_main); end
    request(64, 0);
    vectors++; if (data_main !== 24'h000000) begin miscompares++; $display("FAIL render_64_0: got %h want 000000", data_main); end
    request(0, 64);
    vectors++; if (data_main !== 24'h000000) begin miscompares++; $display("FAIL render_0_64: got %h want 000000", data_main); end
    pix_req = 1'b0; pix_x = 11'd0; pix_y = 11'd0;
    tick();
    vectors++; if (valid_main !== 1'b0 || data_main !== 24'h0) begin miscompares++; $display("FAIL render_idle: got %b/%h want 0/000000", valid_main, data_main); end
  endtask

  task automatic test_update();
    pulse(0, 1);
    vectors++; if (dut.x_pos !== 11'd2 || dut.y_pos !== 11'd2) begin miscompares++; $display("FAIL update_pos: got %0d,%0d want 2,2", dut.x_pos, dut.y_pos); end
    request(1, 1);
    vectors++; if (data_main !== 24'h000000) begin miscompares++; $display("FAIL update_11: got %h want 000000", data_main); end
    request(2, 2);
    vectors++; if (data_main !== 24'hFF0000) begin miscompares++; $display("FAIL update_22: got %h want ff0000", data_main); end
    request(65, 65);
    vectors++; if (data_main !== 24'hFF0000) begin miscompares++; $display("FAIL update_65: got %h want ff0000", data_main); end
    request(66, 66);
    vectors++; if (data_main !== 24'h000000) begin miscompares++; $display("FAIL update_66: got %h want 000000", data_main); end
    pix_req = 1'b0;
  endtask

  task automatic test_coincident();
    fs_main = 1'b1;
    request(2, 2);
    fs_main = 1'b0;
    vectors++; if (data_main !== 24'hFF0000) begin miscompares++; $display("FAIL coincident_old: got %h want ff0000", data_main); end
    vectors++; if (dut.x_pos !== 11'd4) begin miscompares++; $display("FAIL coincident_pos: got %0d want 4", dut.x_pos); end
    request(2, 2);
    vectors++; if (data_main !== 24'h000000) begin miscompares++; $display("FAIL coincident_new: got %h want 000000", data_main); end
    pix_req = 1'b0;
  endtask

  task automatic test_pause_and_div();
    pulse(1, 1);
    vectors++; if (dut_div3.frame_cnt !== 8'd1 || dut_div3.x_pos !== 11'd0) begin miscompares++; $display("FAIL div_p1: got cnt %0d x %0d want 1 0", dut_div3.frame_cnt, dut_div3.x_pos); end
    pause = 1'b1;
    pulse(3, 5);
    pause = 1'b0;
    vectors++; if (dut.x_pos !== 11'd4 || dut.y_pos !== 11'd4 || dut.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL pause_main: got %0d,%0d cnt %0d want 4,4 cnt 0", dut.x_pos, dut.y_pos, dut.frame_cnt); end
    vectors++; if (dut_div3.frame_cnt !== 8'd1 || dut_div3.x_pos !== 11'd0) begin miscompares++; $display("FAIL pause_div3: got cnt %0d x %0d want 1 0", dut_div3.frame_cnt, dut_div3.x_pos); end
    pulse(1, 1);
    vectors++; if (dut_div3.frame_cnt !== 8'd2 || dut_div3.x_pos !== 11'd0) begin miscompares++; $display("FAIL div_p2: got cnt %0d x %0d want 2 0", dut_div3.frame_cnt, dut_div3.x_pos); end
    pulse(1, 1);
    vectors++; if (dut_div3.frame_cnt !== 8'd0 || dut_div3.x_pos !== 11'd2) begin miscompares++; $display("FAIL div_p3: got cnt %0d x %0d want 0 2", dut_div3.frame_cnt, dut_div3.x_pos); end
    pulse(1, 2);
    vectors++; if (dut_div3.x_pos !== 11'd2 || dut_div3.frame_cnt !== 8'd2) begin miscompares++; $display("FAIL div_p5: got cnt %0d x %0d want 2 2", dut_div3.frame_cnt, dut_div3.x_pos); end
    pulse(1, 1);
    vectors++; if (dut_div3.x_pos !== 11'd4 || dut_div3.y_pos !== 11'd4) begin miscompares++; $display("FAIL div_p6: got %0d,%0d want 4,4", dut_div3.x_pos, dut_div3.y_pos); end
  endtask

  // The main square has moved twice. 285 more updates bring x to 574. Y
  // bounced at update 208 (y=416) and has since fallen back to 258.
  task automatic test_bounce_x();
    pulse(0, 285);
    vectors++; if (dut.x_pos !== 11'd574 || dut.dir_x !== 1'b1) begin miscompares++; $display("FAIL bx_pre_x: got %0d dir %b want 574 1", dut.x_pos, dut.dir_x); end
    vectors++; if (dut.y_pos !== 11'd258 || dut.dir_y !== 1'b0 || dut.color_idx !== 2'd1) begin miscompares++; $display("FAIL bx_pre_y: got %0d dir %b col %0d want 258 0 1", dut.y_pos, dut.dir_y, dut.color_idx); end
    request(600, 300);
    vectors++; if (data_main !== 24'h00FF00) begin miscompares++; $display("FAIL bx_pre_pix: got %h want 00ff00", data_main); end
    pix_req = 1'b0;
    pulse(0, 1);
    vectors++; if (dut.x_pos !== 11'd576 || dut.dir_x !== 1'b0) begin miscompares++; $display("FAIL bx_x: got %0d dir %b want 576 0", dut.x_pos, dut.dir_x); end
    vectors++; if (dut.y_pos !== 11'd256 || dut.color_idx !== 2'd2) begin miscompares++; $display("FAIL bx_y_col: got y %0d col %0d want 256 2", dut.y_pos, dut.color_idx); end
    request(600, 300);
    vectors++; if (data_main !== 24'h0000FF) begin miscompares++; $display("FAIL bx_pix_in: got %h want 0000ff", data_main); end
    request(575, 300);
    vectors++; if (data_main !== 24'h000000) begin miscompares++; $display("FAIL bx_pix_out: got %h want 000000", data_main); end
    pix_req = 1'b0;
  endtask

  // In the 16x16 field, x and y always move together, so every bounce is a
  // corner bounce: at update 6 (10 -> 12, far edge) and at update 12 (2 -> 0).
  task automatic test_corner();
    pulse(2, 6);
    vectors++; if (dut_small.x_pos !== 11'd12 || dut_small.y_pos !== 11'd12) begin miscompares++; $display("FAIL corner_far_pos: got %0d,%0d want 12,12", dut_small.x_pos, dut_small.y_pos); end
    vectors++; if (dut_small.dir_x !== 1'b0 || dut_small.dir_y !== 1'b0 || dut_small.color_idx !== 2'd1) begin miscompares++; $display("FAIL corner_far_st: got %b%b col %0d want 00 1", dut_small.dir_x, dut_small.dir_y, dut_small.color_idx); end
    pulse(2, 6);
    vectors++; if (dut_small.x_pos !== 11'd0 || dut_small.y_pos !== 11'd0) begin miscompares++; $display("FAIL corner_near_pos: got %0d,%0d want 0,0", dut_small.x_pos, dut_small.y_pos); end
    vectors++; if (dut_small.dir_x !== 1'b1 || dut_small.dir_y !== 1'b1 || dut_small.color_idx !== 2'd2) begin miscompares++; $display("FAIL corner_near_st: got %b%b col %0d want 11 2", dut_small.dir_x, dut_small.dir_y, dut_small.color_idx); end
    request(3, 3);
    vectors++; if (data_small !== 24'h0000FF) begin miscompares++; $display("FAIL corner_pix_in: got %h want 0000ff", data_small); end
    request(4, 0);
    vectors++; if (data_small !== 24'h000000) begin miscompares++; $display("FAIL corner_pix_out: got %h want 000000", data_small); end
    pix_req = 1'b0;
  endtask

  task automatic test_reset_async();
    request(600, 300);
    vectors++; if (valid_main !== 1'b1 || data_main !== 24'h0000FF) begin miscompares++; $display("FAIL ar_pre: got %b/%h want 1/0000ff", valid_main, data_main); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (valid_main !== 1'b0 || data_main !== 24'h0) begin miscompares++; $display("FAIL ar_out: got %b/%h want 0/000000", valid_main, data_main); end
    vectors++; if (dut.x_pos !== 11'd0 || dut.y_pos !== 11'd0 || dut.dir_x !== 1'b1 || dut.dir_y !== 1'b1) begin miscompares++; $display("FAIL ar_state: got %0d,%0d dir %b%b want 0,0 11", dut.x_pos, dut.y_pos, dut.dir_x, dut.dir_y); end
    vectors++; if (dut.color_idx !== 2'd0 || dut.frame_cnt !== 8'd0) begin miscompares++; $display("FAIL ar_cnt: got col %0d cnt %0d want 0 0", dut.color_idx, dut.frame_cnt); end
    tick();
    rst_n = 1'b1;
    pix_req = 1'b0;
    pulse(0, 1);
    vectors++; if (dut.x_pos !== 11'd2 || dut.y_pos !== 11'd2 || dut.color_idx !== 2'd0) begin miscompares++; $display("FAIL ar_first_upd: got %0d,%0d col %0d want 2,2 0", dut.x_pos, dut.y_pos, dut.color_idx); end
  endtask

  initial begin
    test_reset();
    test_render();
    test_update();
    test_coincident();
    test_pause_and_div();
    test_bounce_x();
    test_corner();
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
